// File: rtl/matching_memory_pkg.sv
// Shared definitions for the matching memory: field widths, dest_option codes,
// token/FSM types, worker-result field extractors and the packet-request builder.
package matching_memory_pkg;

    localparam int DEST_OPTION_WIDTH    = 3;
    localparam int DEST_ADDR_WIDTH      = 10;
    localparam int COLOR_WIDTH          = 16;
    localparam int DATA_WIDTH           = 32;
    localparam int TAG_WIDTH            = DEST_ADDR_WIDTH + COLOR_WIDTH;
    localparam int WORKER_RESULT_WIDTH  = DEST_OPTION_WIDTH + TAG_WIDTH + DATA_WIDTH;
    localparam int PACKET_REQUEST_WIDTH = DEST_OPTION_WIDTH + TAG_WIDTH + 2 * DATA_WIDTH;

    localparam logic [2:0] DEST_OPTION_EXEC  = 3'b001;
    localparam logic [2:0] DEST_OPTION_ONE   = 3'b010;
    localparam logic [2:0] DEST_OPTION_LEFT  = 3'b011;
    localparam logic [2:0] DEST_OPTION_RIGHT = 3'b100;
    localparam logic [2:0] DEST_OPTION_END   = 3'b111;

    typedef enum logic {
        SIDE_LEFT,
        SIDE_RIGHT
    } side_e;

    typedef enum logic [1:0] {
        S_RECEIVE,
        S_LOOKUP,
        S_PR_SEND
    } state_e;

    typedef struct packed {
        side_e                 side;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    function automatic logic [DEST_OPTION_WIDTH-1:0] wr_dest_option(
        input logic [WORKER_RESULT_WIDTH-1:0] wr);
        return wr[60:58];
    endfunction

    function automatic logic [DEST_ADDR_WIDTH-1:0] wr_dest_addr(
        input logic [WORKER_RESULT_WIDTH-1:0] wr);
        return wr[57:48];
    endfunction

    function automatic logic [COLOR_WIDTH-1:0] wr_color(
        input logic [WORKER_RESULT_WIDTH-1:0] wr);
        return wr[47:32];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wr_data(
        input logic [WORKER_RESULT_WIDTH-1:0] wr);
        return wr[31:0];
    endfunction

    function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
        input logic [DEST_OPTION_WIDTH-1:0] dest_option,
        input logic [DEST_ADDR_WIDTH-1:0]   dest_addr,
        input logic [COLOR_WIDTH-1:0]       color,
        input logic [DATA_WIDTH-1:0]        data1,
        input logic [DATA_WIDTH-1:0]        data2);
        return {dest_option, dest_addr, color, data1, data2};
    endfunction

endpackage

// File: rtl/matching_memory_if.sv
// Handshake bundle of the matching memory.
//   RECEIVE_WR_*  worker-result input channel (VALID/DATA from master, READY from slave)
//   SEND_PR_*     packet-request output channel (VALID/DATA from slave, READY from master)
// master = dispatcher/loader side, slave = matching memory.
interface matching_memory_if;
    import matching_memory_pkg::*;

    logic                            RECEIVE_WR_VALID;
    logic [WORKER_RESULT_WIDTH-1:0]  RECEIVE_WR_DATA;
    logic                            RECEIVE_WR_READY;
    logic                            SEND_PR_VALID;
    logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA;
    logic                            SEND_PR_READY;

    modport master (
        output RECEIVE_WR_VALID,
        output RECEIVE_WR_DATA,
        input  RECEIVE_WR_READY,
        input  SEND_PR_VALID,
        input  SEND_PR_DATA,
        output SEND_PR_READY
    );

    modport slave (
        input  RECEIVE_WR_VALID,
        input  RECEIVE_WR_DATA,
        output RECEIVE_WR_READY,
        output SEND_PR_VALID,
        output SEND_PR_DATA,
        input  SEND_PR_READY
    );

endinterface

// File: rtl/matching_memory_token_table.sv
// 2-way set-associative token store.
//   CLK, RST       clock, synchronous active-high reset (clears all valid bits)
//   index, tag     lookup key; hit/hit_side/hit_data/full are combinational
//   write_en       store {write_side, tag, write_data} in the first free way
//   invalidate_en  clear the way that hit
//   occupancy      number of valid entries
// The caller only writes on a miss with a free way and only invalidates on a
// hit, so a tag is never present in both ways at once.
module matching_memory_token_table
    import matching_memory_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]   tag,
    output logic                   hit,
    output side_e                  hit_side,
    output logic [DATA_WIDTH-1:0]  hit_data,
    output logic                   full,
    input  logic                   write_en,
    input  side_e                  write_side,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   invalidate_en,
    output logic [INDEX_WIDTH+1:0] occupancy
);

    localparam int SETS = 1 << INDEX_WIDTH;

    logic [1:0] valid [SETS];
    entry_t     way_entry [2][SETS];

    logic [1:0] set_valid;
    entry_t     entry0;
    entry_t     entry1;
    logic       hit0;
    logic       hit1;
    logic       hit_way;
    logic       free_way;

    always_comb begin
        set_valid = valid[index];
        entry0    = way_entry[0][index];
        entry1    = way_entry[1][index];
        hit0      = set_valid[0] && (entry0.tag == tag);
        hit1      = set_valid[1] && (entry1.tag == tag);
        hit       = hit0 || hit1;
        hit_way   = !hit0;
        hit_side  = hit0 ? entry0.side : entry1.side;
        hit_data  = hit0 ? entry0.data : entry1.data;
        full      = &set_valid;
        free_way  = set_valid[0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                valid[i] <= '0;
            end
            occupancy <= '0;
        end else if (write_en) begin
            valid[index][free_way] <= 1'b1;
            occupancy              <= occupancy + 1'b1;
        end else if (invalidate_en) begin
            valid[index][hit_way] <= 1'b0;
            occupancy             <= occupancy - 1'b1;
        end
    end

    // Payload storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge CLK) begin
        if (write_en) begin
            way_entry[free_way][index] <= '{side: write_side, tag: tag, data: write_data};
        end
    end

endmodule

// File: rtl/matching_memory.sv
// Operand-pairing stage: holds the first LEFT/RIGHT operand of each
// (dest_addr, color) pair and emits one EXEC packet request when the partner
// arrives. One token in flight.
//   CLK, RST        clock, synchronous active-high reset
//   bus             slave side of matching_memory_if (worker results in, packet requests out)
//   OCCUPANCY       number of stored tokens
//   OVERFLOW        sticky: token dropped because its set was full of other tags
//   PROTOCOL_ERROR  sticky: bad dest_option or same-side duplicate tag
module matching_memory
    import matching_memory_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    matching_memory_if.slave       bus,
    output logic [INDEX_WIDTH+1:0] OCCUPANCY,
    output logic                   OVERFLOW,
    output logic                   PROTOCOL_ERROR
);

    state_e state;
    state_e state_next;

    logic [WORKER_RESULT_WIDTH-1:0]  token;
    logic                            ready;
    logic                            ready_next;
    logic                            pr_valid;
    logic                            pr_valid_next;
    logic [PACKET_REQUEST_WIDTH-1:0] pr_data;
    logic [PACKET_REQUEST_WIDTH-1:0] pr_build;

    logic capture;
    logic load_pr;
    logic write_en;
    logic invalidate_en;
    logic set_overflow;
    logic set_protocol_error;

    logic [DEST_OPTION_WIDTH-1:0] tok_option;
    logic [DEST_ADDR_WIDTH-1:0]   tok_addr;
    logic [COLOR_WIDTH-1:0]       tok_color;
    logic [DATA_WIDTH-1:0]        tok_data;
    logic [INDEX_WIDTH-1:0]       tok_index;
    side_e                        tok_side;
    logic                         tok_option_ok;

    logic                  hit;
    side_e                 hit_side;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  full;

    always_comb begin
        tok_option    = wr_dest_option(token);
        tok_addr      = wr_dest_addr(token);
        tok_color     = wr_color(token);
        tok_data      = wr_data(token);
        tok_index     = tok_addr[INDEX_WIDTH-1:0] ^ tok_color[INDEX_WIDTH-1:0];
        tok_side      = (tok_option == DEST_OPTION_RIGHT) ? SIDE_RIGHT : SIDE_LEFT;
        tok_option_ok = (tok_option == DEST_OPTION_LEFT) || (tok_option == DEST_OPTION_RIGHT);
        // data1 is always the LEFT operand regardless of arrival order.
        if (tok_side == SIDE_LEFT) begin
            pr_build = make_packet_request(DEST_OPTION_EXEC, tok_addr, tok_color, tok_data, hit_data);
        end else begin
            pr_build = make_packet_request(DEST_OPTION_EXEC, tok_addr, tok_color, hit_data, tok_data);
        end
    end

    matching_memory_token_table #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_token_table (
        .CLK           (CLK),
        .RST           (RST),
        .index         (tok_index),
        .tag           ({tok_addr, tok_color}),
        .hit           (hit),
        .hit_side      (hit_side),
        .hit_data      (hit_data),
        .full          (full),
        .write_en      (write_en),
        .write_side    (tok_side),
        .write_data    (tok_data),
        .invalidate_en (invalidate_en),
        .occupancy     (OCCUPANCY)
    );

    // READY and SEND_PR_VALID are registered: each is raised one cycle after
    // entering its state, which sets the H+3 / P+2 handshake spacing.
    always_comb begin
        state_next         = state;
        ready_next         = 1'b0;
        pr_valid_next      = 1'b0;
        capture            = 1'b0;
        load_pr            = 1'b0;
        write_en           = 1'b0;
        invalidate_en      = 1'b0;
        set_overflow       = 1'b0;
        set_protocol_error = 1'b0;
        case (state)
            S_RECEIVE: begin
                ready_next = 1'b1;
                if (ready && bus.RECEIVE_WR_VALID) begin
                    capture    = 1'b1;
                    ready_next = 1'b0;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_next = S_RECEIVE;
                if (!tok_option_ok) begin
                    set_protocol_error = 1'b1;
                end else if (hit) begin
                    if (hit_side != tok_side) begin
                        invalidate_en = 1'b1;
                        load_pr       = 1'b1;
                        state_next    = S_PR_SEND;
                    end else begin
                        set_protocol_error = 1'b1;
                    end
                end else if (full) begin
                    set_overflow = 1'b1;
                end else begin
                    write_en = 1'b1;
                end
            end
            S_PR_SEND: begin
                pr_valid_next = 1'b1;
                if (pr_valid && bus.SEND_PR_READY) begin
                    pr_valid_next = 1'b0;
                    state_next    = S_RECEIVE;
                end
            end
            default: begin
                state_next = S_RECEIVE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_RECEIVE;
            token          <= '0;
            ready          <= 1'b0;
            pr_valid       <= 1'b0;
            pr_data        <= '0;
            OVERFLOW       <= 1'b0;
            PROTOCOL_ERROR <= 1'b0;
        end else begin
            state    <= state_next;
            ready    <= ready_next;
            pr_valid <= pr_valid_next;
            if (capture) begin
                token <= bus.RECEIVE_WR_DATA;
            end
            if (load_pr) begin
                pr_data <= pr_build;
            end
            if (set_overflow) begin
                OVERFLOW <= 1'b1;
            end
            if (set_protocol_error) begin
                PROTOCOL_ERROR <= 1'b1;
            end
        end
    end

    assign bus.RECEIVE_WR_READY = ready;
    assign bus.SEND_PR_VALID    = pr_valid;
    assign bus.SEND_PR_DATA     = pr_data;

endmodule

// File: tb/tb_matching_memory.sv
// Self-checking bench for matching_memory: directed scenarios plus randomized
// tokens, compared every cycle against a tag-keyed behavioural model.
module tb_matching_memory;

    localparam logic [2:0] OPT_EXEC  = 3'b001;
    localparam logic [2:0] OPT_LEFT  = 3'b011;
    localparam logic [2:0] OPT_RIGHT = 3'b100;
    localparam int         INF       = 32'h7fffffff;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] occ;
    logic       ovf;
    logic       perr;

    always #5 CLK = ~CLK;

    matching_memory_if bus();

    matching_memory #(
        .INDEX_WIDTH(6)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .bus            (bus),
        .OCCUPANCY      (occ),
        .OVERFLOW       (ovf),
        .PROTOCOL_ERROR (perr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          right;
        logic [31:0] data;
    } ment_t;

    ment_t       mtab [logic [25:0]];
    int          set_cnt [64];
    logic [92:0] prq [$];
    int          cyc       = 0;
    bit          started   = 0;
    int          ready_at  = INF;
    int          valid_from = INF;
    bit          pr_pend   = 0;
    int          apply_at  = -1;
    int          m_occ = 0, p_occ = 0;
    bit          m_ovf = 0, p_ovf = 0, m_perr = 0, p_perr = 0;
    logic [92:0] last_pr = '0;
    int          pr_count = 0;

    task automatic model_token(input logic [60:0] d);
        logic [2:0]  opt;
        logic [9:0]  a;
        logic [15:0] c;
        logic [31:0] v;
        logic [25:0] key;
        int          s;
        bit          right;
        opt   = d[60:58];
        a     = d[57:48];
        c     = d[47:32];
        v     = d[31:0];
        key   = {a, c};
        s     = int'(a[5:0] ^ c[5:0]);
        right = (opt == OPT_RIGHT);
        p_occ    = m_occ;
        p_ovf    = m_ovf;
        p_perr   = m_perr;
        apply_at = cyc + 2;
        ready_at = cyc + 3;
        if (opt != OPT_LEFT && opt != OPT_RIGHT) begin
            p_perr = 1;
        end else if (mtab.exists(key)) begin
            if (mtab[key].right == right) begin
                p_perr = 1;
            end else begin
                if (right) prq.push_back({OPT_EXEC, a, c, mtab[key].data, v});
                else       prq.push_back({OPT_EXEC, a, c, v, mtab[key].data});
                pr_pend    = 1;
                valid_from = cyc + 3;
                ready_at   = INF;
                mtab.delete(key);
                set_cnt[s]--;
                p_occ--;
            end
        end else if (set_cnt[s] == 2) begin
            p_ovf = 1;
        end else begin
            mtab[key] = '{right: right, data: v};
            set_cnt[s]++;
            p_occ++;
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge CLK) begin
        bit exp_valid;
        cyc++;
        if (RST === 1'b1) begin
            started  = 1;
            ready_at = cyc + 2;
            pr_pend  = 0;
            prq.delete();
            mtab.delete();
            foreach (set_cnt[i]) set_cnt[i] = 0;
            m_occ = 0; m_ovf = 0; m_perr = 0;
            apply_at = -1;
        end else if (started) begin
            if (cyc == apply_at) begin
                m_occ = p_occ; m_ovf = p_ovf; m_perr = p_perr;
            end
            exp_valid = pr_pend && (cyc >= valid_from);
            chk("wr_ready", bus.RECEIVE_WR_READY, cyc >= ready_at);
            chk("pr_valid", bus.SEND_PR_VALID, exp_valid);
            if (exp_valid && bus.SEND_PR_VALID) chk("pr_data", bus.SEND_PR_DATA, prq[0]);
            chk("occupancy", occ, m_occ);
            chk("overflow", ovf, m_ovf);
            chk("protocol_error", perr, m_perr);
            if (exp_valid && bus.SEND_PR_VALID && bus.SEND_PR_READY) begin
                last_pr = bus.SEND_PR_DATA;
                pr_count++;
                void'(prq.pop_front());
                pr_pend  = 0;
                ready_at = cyc + 2;
            end
            if (bus.RECEIVE_WR_VALID && bus.RECEIVE_WR_READY) model_token(bus.RECEIVE_WR_DATA);
        end
    end

    // ---------------- stimulus ----------------
    bit lr_random = 0;
    bit lr_force  = 1;

    always @(posedge CLK) begin
        #1;
        bus.SEND_PR_READY = lr_random ? 1'($urandom_range(0, 1)) : lr_force;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic send(input logic [2:0] opt, input logic [9:0] a, input logic [15:0] c,
                        input logic [31:0] d);
        int n;
        @(posedge CLK); #1;
        bus.RECEIVE_WR_VALID = 1'b1;
        bus.RECEIVE_WR_DATA  = {opt, a, c, d};
        n = 0;
        @(negedge CLK);
        while (!bus.RECEIVE_WR_READY && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout wr_ready=0 required 1 within 200 cycles");
        end
        @(posedge CLK); #1;
        bus.RECEIVE_WR_VALID = 1'b0;
    endtask

    task automatic wait_pr(input int target);
        int n;
        n = 0;
        while (pr_count < target && n < 200) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (pr_count < target) begin
            failures++;
            $display("FAIL wait_pr transfers=%0d required=%0d", pr_count, target);
        end
    endtask

    initial begin
        int          c0;
        logic [2:0]  opt;
        logic [2:0]  bad_opts [6];
        bad_opts = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
        RST = 1'b1;
        bus.RECEIVE_WR_VALID = 1'b0;
        bus.RECEIVE_WR_DATA  = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_occ", occ, 8'd0);
        chk("reset_pr_valid", bus.SEND_PR_VALID, 1'b0);
        chk("reset_pr_data", bus.SEND_PR_DATA, 93'd0);
        chk("reset_ready", bus.RECEIVE_WR_READY, 1'b0);
        chk("reset_flags", {ovf, perr}, 2'b00);

        // LEFT then RIGHT on one tag
        send(OPT_LEFT, 10'd5, 16'd1, 32'h10);
        idle(4);
        chk("t1_occ_stored", occ, 8'd1);
        c0 = pr_count;
        send(OPT_RIGHT, 10'd5, 16'd1, 32'h20);
        wait_pr(c0 + 1);
        chk("t1_pr", last_pr, {3'b001, 10'd5, 16'd1, 32'h10, 32'h20});
        idle(3);
        chk("t1_occ_empty", occ, 8'd0);

        // RIGHT before LEFT: data1 is still the LEFT operand
        c0 = pr_count;
        send(OPT_RIGHT, 10'd7, 16'd3, 32'hAA);
        send(OPT_LEFT, 10'd7, 16'd3, 32'hBB);
        wait_pr(c0 + 1);
        chk("t2_pr", last_pr, {3'b001, 10'd7, 16'd3, 32'hBB, 32'hAA});

        // Three tags in set 0
        send(OPT_LEFT, 10'd0, 16'd0, 32'h1);
        send(OPT_LEFT, 10'd1, 16'd1, 32'h2);
        send(OPT_LEFT, 10'd2, 16'd2, 32'h3);
        idle(4);
        chk("t3_overflow", ovf, 1'b1);
        chk("t3_occ", occ, 8'd2);
        do_reset();

        // Loader stalls 10+ cycles after a match
        lr_force = 0;
        c0 = pr_count;
        send(OPT_LEFT, 10'd9, 16'd0, 32'h1);
        send(OPT_RIGHT, 10'd9, 16'd0, 32'h2);
        idle(14);
        @(negedge CLK);
        chk("t4_held_valid", bus.SEND_PR_VALID, 1'b1);
        chk("t4_held_data", bus.SEND_PR_DATA, {3'b001, 10'd9, 16'd0, 32'h1, 32'h2});
        lr_force = 1;
        wait_pr(c0 + 1);
        idle(6);
        chk("t4_single_transfer", pr_count, c0 + 1);

        // Duplicate same-side tag, then a non-LEFT/RIGHT option
        send(OPT_LEFT, 10'd12, 16'd4, 32'h5);
        send(OPT_LEFT, 10'd12, 16'd4, 32'h6);
        idle(4);
        chk("t5_perr_dup", perr, 1'b1);
        chk("t5_occ_dup", occ, 8'd1);
        do_reset();
        send(OPT_LEFT, 10'd3, 16'd3, 32'h7);
        send(OPT_EXEC, 10'd3, 16'd3, 32'h8);
        idle(4);
        chk("t5_perr_exec", perr, 1'b1);
        chk("t5_occ_exec", occ, 8'd1);
        c0 = pr_count;
        send(OPT_RIGHT, 10'd3, 16'd3, 32'h9);
        wait_pr(c0 + 1);
        chk("t5_pr_after_exec", last_pr, {3'b001, 10'd3, 16'd3, 32'h7, 32'h9});

        // Reset while a request is pending
        do_reset();
        lr_force = 0;
        send(OPT_LEFT, 10'd20, 16'd5, 32'h11);
        send(OPT_RIGHT, 10'd20, 16'd5, 32'h22);
        idle(4);
        do_reset();
        @(negedge CLK);
        chk("t6_valid_after_rst", bus.SEND_PR_VALID, 1'b0);
        chk("t6_occ_after_rst", occ, 8'd0);
        chk("t6_flags_after_rst", {ovf, perr}, 2'b00);
        lr_force = 1;
        c0 = pr_count;
        send(OPT_RIGHT, 10'd20, 16'd5, 32'h33);
        idle(6);
        chk("t6_occ_restored", occ, 8'd1);
        chk("t6_no_pr", pr_count, c0);

        // Randomized traffic over a few crowded sets
        do_reset();
        lr_random = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) opt = bad_opts[$urandom_range(0, 5)];
            else opt = ($urandom_range(0, 1) != 0) ? OPT_RIGHT : OPT_LEFT;
            send(opt,
                 10'($urandom_range(0, 3) + 64 * $urandom_range(0, 1)),
                 16'($urandom_range(0, 3)),
                 $urandom);
            if ($urandom_range(0, 49) == 0) do_reset();
            idle($urandom_range(0, 2));
        end
        lr_random = 0;
        lr_force  = 1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
